// File: rtl/data_memory_mmio.sv
// Data memory with a 16-word memory-mapped I/O window: GPIO output register,
// a byte-wide TX FIFO with status, and a free-running cycle counter.
// Reads are registered (one-cycle latency, read-before-write). The reset
// input rst_n is active-high and synchronous despite its name.
module data_memory_mmio #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [10:0] MMIO_BASE  = 11'h7F0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] D_ADDR,
    input  logic [31:0] D_OUT,
    input  logic        dm_oen,
    input  logic        dm_wen,
    output logic [31:0] D_IN,
    output logic [31:0] gpio_out,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int unsigned PtrW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW     = PtrW + 1;
    localparam int unsigned RamWords = int'(MMIO_BASE);

    logic [31:0]     ram_q [0:RamWords-1];
    logic [7:0]      fifo_q [0:FIFO_DEPTH-1];
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] count_q;
    logic            overflow_q;
    logic [31:0]     gpio_q, cycle_q, d_in_q;

    logic            is_ram, is_io;
    logic [10:0]     io_off;
    logic [3:0]      io_sel;
    logic            wr_io, gpio_wr, push, status_wr, cycle_wr;
    logic            pop, full, empty, accept;
    logic [2:0]      count_view;
    logic [31:0]     io_rdata;

    // Address decode and write strobes for the I/O window.
    always_comb begin
        is_ram    = D_ADDR < MMIO_BASE;
        io_off    = D_ADDR - MMIO_BASE;
        is_io     = !is_ram && (io_off < 11'd16);
        io_sel    = io_off[3:0];
        wr_io     = !dm_wen && is_io;
        gpio_wr   = wr_io && (io_sel == 4'd0);
        push      = wr_io && (io_sel == 4'd1);
        status_wr = wr_io && (io_sel == 4'd2);
        cycle_wr  = wr_io && (io_sel == 4'd3);
    end

    // FIFO handshake and status terms; full-with-pop still accepts a push.
    always_comb begin
        full       = count_q == CntW'(FIFO_DEPTH);
        empty      = count_q == '0;
        pop        = !empty && tx_ready;
        accept     = push && (!full || pop);
        count_view = (32'(count_q) > 32'd7) ? 3'd7 : 3'(count_q);
    end

    // I/O read mux; unmapped offsets and the TX port read as zero.
    always_comb begin
        io_rdata = '0;
        if (is_io) begin
            case (io_sel)
                4'd0:    io_rdata = gpio_q;
                4'd2:    io_rdata = {26'b0, overflow_q, empty, full, count_view};
                4'd3:    io_rdata = cycle_q;
                default: io_rdata = '0;
            endcase
        end
    end

    // RAM array: no reset, writes blocked on reset edges.
    always_ff @(posedge clk) begin
        if (!rst_n && !dm_wen && is_ram) begin
            ram_q[D_ADDR] <= D_OUT;
        end
    end

    // Registered read data; samples pre-write state so reads see old values.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            d_in_q <= '0;
        end else if (!dm_oen) begin
            d_in_q <= is_ram ? ram_q[D_ADDR] : io_rdata;
        end
    end

    // GPIO register and cycle counter; a counter write replaces the increment.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            gpio_q  <= '0;
            cycle_q <= '0;
        end else begin
            if (gpio_wr) gpio_q <= D_OUT;
            cycle_q <= cycle_wr ? D_OUT : cycle_q + 32'd1;
        end
    end

    // TX FIFO storage, pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                fifo_q[wr_ptr_q] <= D_OUT[7:0];
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // A dropped byte wins over a clear in the same cycle.
            if (push && full && !pop) begin
                overflow_q <= 1'b1;
            end else if (status_wr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign D_IN     = d_in_q;
    assign gpio_out = gpio_q;
    assign tx_valid = !empty;
    assign tx_data  = fifo_q[rd_ptr_q];

endmodule

// File: doc/data_memory_mmio.md
DATA_MEMORY_MMIO -- requirements
Module: data_memory_mmio

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: TX FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter MMIO_BASE, default 11'h7F0: base of the 16-word I/O window.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-high (asserted = 1).
REQ-005 SHALL have port D_ADDR, input, 11: word address from core.
REQ-006 SHALL have port D_OUT, input, 32: write data from core.
REQ-007 SHALL have port dm_oen, input, 1: read enable, active-low.
REQ-008 SHALL have port dm_wen, input, 1: write enable, active-low.
REQ-009 SHALL have port D_IN, output, 32: registered read data to core.
REQ-010 SHALL have port gpio_out, output, 32: GPIO output register.
REQ-011 SHALL have port tx_data, output, 8: FIFO head byte.
REQ-012 SHALL have port tx_valid, output, 1: FIFO non-empty.
REQ-013 SHALL have port tx_ready, input, 1: consumer accepts head byte.

Function
REQ-014 SHALL decode D_ADDR < MMIO_BASE as RAM (MMIO_BASE words x 32 bits); MMIO_BASE..MMIO_BASE+15 as I/O.
REQ-015 SHALL, on an edge with dm_oen=0, load D_IN with the addressed RAM word or I/O value; one-cycle read latency.
REQ-016 SHALL hold D_IN unchanged on edges with dm_oen=1.
REQ-017 SHALL, on an edge with dm_wen=0, write D_OUT to the addressed RAM word or I/O register.
REQ-018 SHALL, when dm_oen=0 and dm_wen=0 target the same address, return the pre-write value (read-before-write).
REQ-019 SHALL map offset 0 as GPIO: read returns gpio_out; write loads gpio_out with D_OUT.
REQ-020 SHALL map offset 1 as TX: write pushes D_OUT[7:0] into the FIFO; read returns 0 and does not pop.
REQ-021 SHALL map offset 2 as STATUS: read = {26'b0, overflow, empty, full, count[2:0]} (count saturates at 7 in view when FIFO_DEPTH > 7); any write clears overflow.
REQ-022 SHALL map offset 3 as CYCLE: 32-bit counter, +1 every non-reset cycle, wraps 32'hFFFFFFFF -> 0; write loads D_OUT (the increment is suppressed that cycle).
REQ-023 SHALL return 0 on reads of offsets 4..15 and ignore writes to them.
REQ-024 SHALL pop the FIFO on every edge where tx_valid=1 and tx_ready=1.
REQ-025 SHALL drive tx_valid=1 iff count>0 and tx_data = head entry (registered state, no combinational path from tx_ready).
REQ-026 SHALL, on a push while full with no pop, drop the byte and set sticky overflow.
REQ-027 SHALL, on a push while full with a simultaneous pop, accept the byte; count stays FIFO_DEPTH, overflow unchanged.
REQ-028 SHALL, on a push while empty, assert tx_valid on the following cycle.
REQ-029 SHALL, on simultaneous push and pop at 0<count<FIFO_DEPTH, keep count unchanged and preserve order.
REQ-030 SHALL, when a write to STATUS and an overflowing push coincide, leave overflow set.
REQ-031 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH.

Reset
REQ-032 SHALL, while rst_n=1 on an edge, clear D_IN, gpio_out, tx_data, CYCLE, count, pointers, and overflow to 0; tx_valid=0.
REQ-033 SHALL ignore dm_oen/dm_wen/tx_ready on reset edges; RAM contents are not cleared.
REQ-034 SHALL, on reset mid-transfer, discard all FIFO contents; tx_valid=0 on the next cycle.

Verification
REQ-035 SHALL verify RAM: write 0xDEADBEEF @0x010, then read @0x010 -> D_IN=0xDEADBEEF one edge after dm_oen=0; a simultaneous read+write of 0x1 @0x010 returns 0xDEADBEEF.
REQ-036 SHALL verify GPIO/CYCLE: write 0x00A5 to 0x7F0 -> gpio_out=0x00A5; write 0xFFFFFFFE to 0x7F3, read 2 cycles later -> 0x0 (wrap).
REQ-037 SHALL verify FIFO: tx_ready=0, push 0x11..0x15 -> STATUS reads full=1, count=4, overflow=1; tx_ready=1 -> tx_data 0x11,0x12,0x13,0x14, then tx_valid=0.
REQ-038 SHALL verify full push+pop: full FIFO, tx_ready=1 with a push of 0x77 -> count stays 4, overflow unchanged, 0x77 emerges last.
REQ-039 SHALL verify reset: assert rst_n for one edge with 3 bytes queued -> tx_valid=0, STATUS reads 0x10, D_IN=0, gpio_out=0.
